// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multicycle multiply/divide engine.
// Launches the engine, stalls the front of the pipe, and hands the result to X/M.
`timescale 1ns/1ps
module multdiv_sequencer #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_x,
    input  logic [4:0]  op_x,
    input  logic [4:0]  aluop_x,
    input  logic        kill,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        eng_ready,
    input  logic [31:0] eng_result,
    input  logic        eng_exception,
    output logic        eng_start,
    output logic        eng_is_div,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        eng_abort,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        exception,
    output logic [2:0]  rstatus_code
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0]       OP_RTYPE = 5'b00000;
    localparam logic [4:0]       ALU_MULT = 5'b00110;
    localparam logic [4:0]       ALU_DIV  = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             start_cond;
    logic             timeout_hit;

    assign start_cond  = valid_x & (op_x == OP_RTYPE)
                       & ((aluop_x == ALU_MULT) | (aluop_x == ALU_DIV)) & ~kill;
    assign timeout_hit = (counter == CNT_LAST);

    // Pulses are gated by reset so they drop the moment reset asserts,
    // even though start_cond may still be true from a live X instruction.
    always_comb begin
        eng_start    = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        eng_abort    = 1'b0;
        unique case (state)
            IDLE: begin
                eng_start = start_cond;
                stall     = start_cond;
            end
            RUN: begin
                stall     = ~kill;
                eng_abort = kill | (~eng_ready & timeout_hit);
            end
            DONE: result_valid = ~kill;
            default: ;
        endcase
        if (reset) begin
            eng_start    = 1'b0;
            stall        = 1'b0;
            result_valid = 1'b0;
            eng_abort    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            eng_is_div <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
            result     <= '0;
            exception  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_cond) begin
                        eng_a      <= operand_a;
                        eng_b      <= operand_b;
                        eng_is_div <= aluop_x[0];
                        counter    <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    // Priority: kill, then engine result, then timeout.
                    if (kill) begin
                        state <= IDLE;
                    end else if (eng_ready) begin
                        result    <= eng_result;
                        exception <= eng_exception;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        result    <= '0;
                        exception <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rstatus_code = exception ? (eng_is_div ? 3'd5 : 3'd4) : 3'd0;

endmodule
